// File: rtl/bht_btb_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating BHT counters.
// Zero-latency fetch lookup, execute-stage update, mispredict detection and counters.
module bht_btb_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            UpdEnE,
    input  logic [XLEN-1:0] PC_E,
    input  logic            IsJumpE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic [XLEN-1:0] PCP4_E,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]  idx_f, idx_e;
    logic [TAG_W-1:0]  tag_f, tag_e;
    logic              hit_f, hit_e;
    logic [1:0]        ctr_e_d;

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_e = PC_E[IDX_W+1:2];
    assign tag_e = PC_E[IDX_W+TAG_W+1:IDX_W+2];

    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign PredTakenF  = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
    assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + XLEN'(4);

    assign MispredE    = UpdEnE && ((TakenE != PredTakenE) ||
                                    (TakenE && PredTakenE && (TargetE != PredTargetE)));
    assign RedirectPCE = TakenE ? TargetE : PCP4_E;

    always_comb begin
        ctr_e_d = ctr_q[idx_e];
        if (TakenE && ctr_q[idx_e] != 2'b11) begin
            ctr_e_d = ctr_q[idx_e] + 2'b01;
        end else if (!TakenE && ctr_q[idx_e] != 2'b00) begin
            ctr_e_d = ctr_q[idx_e] - 2'b01;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (UpdEnE) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (MispredE) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // Control state (valid/ctr/jump/tag) is reset; targets are only meaningful behind valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                jump_q[i]  <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (UpdEnE) begin
                if (hit_e) begin
                    if (IsJumpE) begin
                        ctr_q[idx_e]  <= 2'b11;
                        jump_q[idx_e] <= 1'b1;
                    end else begin
                        ctr_q[idx_e]  <= ctr_e_d;
                    end
                end else if (TakenE) begin
                    valid_q[idx_e] <= 1'b1;
                    tag_q[idx_e]   <= tag_e;
                    jump_q[idx_e]  <= IsJumpE;
                    ctr_q[idx_e]   <= IsJumpE ? 2'b11 : 2'b10;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                target_q[i] <= '0;
            end
        end else if (UpdEnE && TakenE) begin
            target_q[idx_e] <= TargetE;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench for bht_btb_predictor: allocation, counter hysteresis, aliasing,
// read-during-write, counter wrap (CNT_W=4) and asynchronous reset.
module tb_bht_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdEnE;
    logic [31:0] PC_E;
    logic        IsJumpE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic [31:0] PCP4_E;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredE;
    logic [31:0] RedirectPCE;
    logic [3:0]  BranchCnt;
    logic [3:0]  MispredCnt;

    int n_tests = 0;
    int n_fail  = 0;

    bht_btb_predictor #(
        .XLEN    (32),
        .ENTRIES (64),
        .TAG_W   (8),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .UpdEnE      (UpdEnE),
        .PC_E        (PC_E),
        .IsJumpE     (IsJumpE),
        .TakenE      (TakenE),
        .TargetE     (TargetE),
        .PCP4_E      (PCP4_E),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredE    (MispredE),
        .RedirectPCE (RedirectPCE),
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic en, input logic [31:0] pc, input logic jmp,
                       input logic tkn, input logic [31:0] tgt,
                       input logic ptkn, input logic [31:0] ptgt);
        UpdEnE      = en;
        PC_E        = pc;
        IsJumpE     = jmp;
        TakenE      = tkn;
        TargetE     = tgt;
        PCP4_E      = pc + 32'd4;
        PredTakenE  = ptkn;
        PredTargetE = ptgt;
    endtask

    initial begin
        rst = 1'b0;
        PCF = 32'h100;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        #3;
        check("rst_predtaken", 32'(PredTakenF), 32'd0);
        check("rst_predtarget", PredTargetF, 32'h104);
        check("rst_branchcnt", 32'(BranchCnt), 32'd0);
        check("rst_mispredcnt", 32'(MispredCnt), 32'd0);
        check("rst_mispred", 32'(MispredE), 32'd0);

        @(negedge clk);
        rst = 1'b1;

        // First taken branch 0x100 -> 0x80, predicted not-taken
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        check("alloc_mispred", 32'(MispredE), 32'd1);
        check("alloc_redirect", RedirectPCE, 32'h80);
        check("alloc_lookup_pre", 32'(PredTakenF), 32'd0);

        @(negedge clk);
        upd(1'b0, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        check("alloc_lookup_taken", 32'(PredTakenF), 32'd1);
        check("alloc_lookup_target", PredTargetF, 32'h80);
        check("alloc_mispredcnt", 32'(MispredCnt), 32'd1);
        check("alloc_branchcnt", 32'(BranchCnt), 32'd1);
        check("upd_off_no_mispred", 32'(MispredE), 32'd0);

        // Two correctly predicted takens: ctr 10 -> 11 -> 11
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        check("taken1_mispred", 32'(MispredE), 32'd0);
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        check("taken2_mispred", 32'(MispredE), 32'd0);

        // First not-taken: ctr 11 -> 10
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        check("nt1_mispred", 32'(MispredE), 32'd1);
        check("nt1_redirect", RedirectPCE, 32'h104);

        // Still predicts taken; second not-taken: ctr 10 -> 01
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        check("nt1_still_taken", 32'(PredTakenF), 32'd1);
        check("nt2_mispred", 32'(MispredE), 32'd1);
        check("nt2_redirect", RedirectPCE, 32'h104);

        // Now predicts not-taken; then taken with wrong predicted target (ctr 01 -> 10)
        @(negedge clk);
        upd(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h84);
        #1;
        check("nt2_pred_nottaken", 32'(PredTakenF), 32'd0);
        check("nt2_pred_target", PredTargetF, 32'h104);
        check("tgt_mismatch_mispred", 32'(MispredE), 32'd1);
        check("tgt_mismatch_redirect", RedirectPCE, 32'h80);

        // Alias jump at 0x200 (same idx, different tag) replaces the entry
        @(negedge clk);
        check("re_taken_after_ctr10", 32'(PredTakenF), 32'd1);
        upd(1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        #1;
        check("alias_mispred", 32'(MispredE), 32'd1);
        check("alias_redirect", RedirectPCE, 32'h400);

        @(negedge clk);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("alias_old_miss", 32'(PredTakenF), 32'd0);
        check("alias_old_target", PredTargetF, 32'h104);
        PCF = 32'h200;
        #1;
        check("alias_new_taken", 32'(PredTakenF), 32'd1);
        check("alias_new_target", PredTargetF, 32'h400);
        check("cnt_branch_7", 32'(BranchCnt), 32'd7);
        check("cnt_mispred_5", 32'(MispredCnt), 32'd5);

        // PC+4 wraps modulo 2^32 on a miss
        PCF = 32'hFFFF_FFFC;
        #1;
        check("pcp4_wrap", PredTargetF, 32'h0);

        // 9 correct not-taken updates on a miss: BranchCnt 7 -> 16 wraps to 0
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            upd(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h304);
        end
        @(negedge clk);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("cnt_wrap_branch", 32'(BranchCnt), 32'd0);
        check("cnt_wrap_mispred", 32'(MispredCnt), 32'd5);

        // Asynchronous reset mid-phase with an update in flight
        PCF = 32'h200;
        upd(1'b1, 32'h200, 1'b1, 1'b1, 32'h500, 1'b0, 32'h204);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_predtaken", 32'(PredTakenF), 32'd0);
        check("async_rst_target", PredTargetF, 32'h204);
        check("async_rst_mispredcnt", 32'(MispredCnt), 32'd0);
        @(negedge clk);
        check("rst_discard_branchcnt", 32'(BranchCnt), 32'd0);
        check("rst_discard_predtaken", 32'(PredTakenF), 32'd0);
        rst = 1'b1;

        // Read-during-write at 0x200 after reset
        upd(1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        #1;
        check("rdw_same_cycle", 32'(PredTakenF), 32'd0);
        @(negedge clk);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("rdw_next_cycle", 32'(PredTakenF), 32'd1);
        check("rdw_next_target", PredTargetF, 32'h400);

        // 15 more updates: 16 total since reset wraps BranchCnt to 0
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            upd(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h304);
        end
        @(negedge clk);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("wrap16_branch", 32'(BranchCnt), 32'd0);
        check("wrap16_mispred", 32'(MispredCnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
